lane_rr_merge: RTL

- Downstream consumer of an N-lane interface-array bus: N producer lanes, each a valid/ready handshake carrying W-bit data.
- Merges the lanes round-robin into one buffered output stream, tagging each beat with its source lane index.
- Sits between a per-lane source block (driving a_if-style interface arrays) and a single-stream consumer.
- Interface: lane_if #(.W(W)) with valid, ready, data[W-1:0]; modports source (output valid, data; input ready) and sink (input valid, data; output ready).

---
 rtl/lane_merge_pkg.sv | 11 +
 rtl/lane_if.sv | 8 +
 rtl/lane_rr_merge_rr_arbiter.sv | 27 ++
 rtl/lane_rr_merge.sv | 65 ++++++
 4 files changed

// File: rtl/lane_merge_pkg.sv
// lane_merge_pkg: shared default sizes and FIFO entry type for the lane merger
package lane_merge_pkg;
    localparam int N_DEF = 4;
    localparam int W_DEF = 8;
    localparam int DEPTH_DEF = 4;
    localparam int LW_DEF = $clog2(N_DEF);
    typedef struct packed {
        logic [LW_DEF-1:0] lane;
        logic [W_DEF-1:0]  data;
    } entry_t;
endpackage

// File: rtl/lane_if.sv
// lane_if: single valid/ready lane carrying W-bit data
interface lane_if #(parameter int W = 8);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    modport source (output valid, data, input ready);
    modport sink (input valid, data, output ready);
endinterface

// File: rtl/lane_rr_merge_rr_arbiter.sv
// rr_arbiter: grants the first requester at or after ptr, wrapping mod N
module rr_arbiter #(
    parameter int N = 4,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [LW-1:0] gnt_idx,
    output logic          any_gnt
);
    always_comb begin
        int k;
        gnt_idx = '0;
        any_gnt = 1'b0;
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (en && req[k]) begin
                gnt_idx = LW'(k);
                any_gnt = 1'b1;
            end
        end
        gnt = any_gnt ? N'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/lane_rr_merge.sv
// lane_rr_merge: round-robin merge of N valid/ready lanes into one lane-tagged FIFO stream
module lane_rr_merge import lane_merge_pkg::*; #(
    parameter int N = N_DEF,
    parameter int W = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int LW = $clog2(N),
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    lane_if.sink          i_lane [N-1:0],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [LW-1:0] out_lane,
    output logic [CW-1:0] fifo_count
);
    typedef struct packed {
        logic [LW-1:0] lane;
        logic [W-1:0]  data;
    } ent_t;
    ent_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] rr_ptr, gnt_idx;
    logic [N-1:0]  req, gnt;
    logic [W-1:0]  lane_data [N];
    logic          any_gnt, pop, can_push;
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign req[g] = i_lane[g].valid;
        assign lane_data[g] = i_lane[g].data;
        assign i_lane[g].ready = gnt[g];
    end
    assign out_valid = fifo_count != '0;
    assign pop = out_valid & out_ready;
    assign can_push = (fifo_count < CW'(DEPTH)) | pop;
    assign out_data = mem[rd_ptr].data;
    assign out_lane = mem[rd_ptr].lane;
    // Gating with rst_n drops every ready while reset is held.
    rr_arbiter #(.N(N)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .en      (can_push & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (any_gnt) begin
                mem[wr_ptr] <= '{lane: gnt_idx, data: lane_data[gnt_idx]};
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= (gnt_idx == LW'(N - 1)) ? '0 : gnt_idx + LW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(any_gnt) - CW'(pop);
        end
    end
endmodule
